// File: rtl/pmu_counter_bank.sv
// pmu_counter_bank
// Event-counter register bank of the Lagarto PMU. Serves the PMU AXI bridge's
// counter read/write request interface. It holds a control register (EN, CLR),
// an overflow status register (W1C) and N_COUNTERS 64-bit event counters.
//
// Handshake (both channels): the bridge raises *_enable as a level, holding the
// address/data stable. The level is synchronised (2 flops) into ren_s/wen_s.
// When the FSM is IDLE and sees the synchronised level high, it services the
// request once, raises *_valid and waits in ACK. It drops *_valid (and zeroes
// read data) only after the synchronised level returns low. Exactly one access
// is performed per enable pulse.
//
// Ports:
//   clk_i, rstn_i          bank clock, async active-low reset
//   events_i               per-counter event pulses (one increment per high cycle)
//   counter_read_*         read request level/address, valid/data response
//   counter_write_*        write request level/address/data, valid response
//   overflow_irq_o         registered OR of all overflow flags
//   read_state/write_state FSM state, for observation (0 = IDLE, 1 = ACK)
module pmu_counter_bank #(
  parameter int COUNTER_ADDRESS_WIDTH = 16,
  parameter int COUNTER_DATA_WIDTH    = 64,
  parameter int N_COUNTERS            = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [N_COUNTERS-1:0]            events_i,
  input  logic                             counter_read_enable,
  input  logic [COUNTER_ADDRESS_WIDTH-1:0] counter_read_address,
  output logic                             counter_read_valid,
  output logic [COUNTER_DATA_WIDTH-1:0]    counter_read_data,
  input  logic                             counter_write_enable,
  input  logic [COUNTER_ADDRESS_WIDTH-1:0] counter_write_address,
  input  logic [COUNTER_DATA_WIDTH-1:0]    counter_write_data,
  output logic                             counter_write_valid,
  output logic                             overflow_irq_o,
  output logic [0:0]                       read_state,
  output logic [0:0]                       write_state
);

  localparam int IW = COUNTER_ADDRESS_WIDTH - 3;
  localparam int DW = COUNTER_DATA_WIDTH;
  localparam int N  = N_COUNTERS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  // Register state
  logic          ctrl_en;
  logic [N-1:0]  ovf;
  logic [DW-1:0] cnt      [N];
  logic [DW-1:0] cnt_next [N];
  logic [N-1:0]  ovf_next;

  // Synchronisers
  logic ren_meta, ren_s;
  logic wen_meta, wen_s;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ren_meta <= 1'b0;
      ren_s    <= 1'b0;
      wen_meta <= 1'b0;
      wen_s    <= 1'b0;
    end else begin
      ren_meta <= counter_read_enable;
      ren_s    <= ren_meta;
      wen_meta <= counter_write_enable;
      wen_s    <= wen_meta;
    end
  end

  // Word index; the byte offset within a word is ignored.
  logic [IW-1:0] rd_idx, wr_idx;
  assign rd_idx = counter_read_address[COUNTER_ADDRESS_WIDTH-1:3];
  assign wr_idx = counter_write_address[COUNTER_ADDRESS_WIDTH-1:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{counter_read_address[2:0], counter_write_address[2:0]};

  // Read mux over current register contents; a same-cycle write is not yet
  // visible here, so a colliding read returns the pre-write value.
  logic [DW-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (rd_idx == IW'(0)) begin
      rd_word[0] = ctrl_en;
    end else if (rd_idx == IW'(1)) begin
      rd_word[N-1:0] = ovf;
    end
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IW'(i + 2)) rd_word = cnt[i];
    end
  end

  // Write decode: only the IDLE->ACK transition performs the write.
  logic wr_fire, wr_ctrl, wr_ovf, clr_fire;
  logic [N-1:0] wr_cnt;
  always_comb begin
    wr_fire  = (write_state == ST_IDLE) && wen_s;
    wr_ctrl  = wr_fire && (wr_idx == IW'(0));
    wr_ovf   = wr_fire && (wr_idx == IW'(1));
    clr_fire = wr_ctrl && counter_write_data[1];
    wr_cnt   = '0;
    for (int i = 0; i < N; i++) begin
      wr_cnt[i] = wr_fire && (wr_idx == IW'(i + 2));
    end
  end

  // Counter next-state: CLR beats bus write beats increment. Overflow is only
  // flagged when the wrapping increment actually lands.
  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf & ~(wr_ovf ? counter_write_data[N-1:0] : {N{1'b0}});
    for (int i = 0; i < N; i++) begin
      if (clr_fire) begin
        cnt_next[i] = '0;
      end else if (wr_cnt[i]) begin
        cnt_next[i] = counter_write_data;
      end else if (ctrl_en && events_i[i]) begin
        cnt_next[i] = cnt[i] + DW'(1);
        // New overflow set wins over a W1C of the same bit.
        if (cnt[i] == {DW{1'b1}}) ovf_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_en        <= 1'b0;
      ovf            <= '0;
      overflow_irq_o <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      // A write carrying CLR is a clear command only; EN keeps its value.
      if (wr_ctrl && !counter_write_data[1]) ctrl_en <= counter_write_data[0];
      ovf            <= ovf_next;
      overflow_irq_o <= |ovf;
      for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Read FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      read_state         <= ST_IDLE;
      counter_read_valid <= 1'b0;
      counter_read_data  <= '0;
    end else begin
      case (read_state)
        ST_IDLE: begin
          if (ren_s) begin
            counter_read_data  <= rd_word;
            counter_read_valid <= 1'b1;
            read_state         <= ST_ACK;
          end
        end
        default: begin
          if (!ren_s) begin
            counter_read_data  <= '0;
            counter_read_valid <= 1'b0;
            read_state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      write_state         <= ST_IDLE;
      counter_write_valid <= 1'b0;
    end else begin
      case (write_state)
        ST_IDLE: begin
          if (wen_s) begin
            counter_write_valid <= 1'b1;
            write_state         <= ST_ACK;
          end
        end
        default: begin
          if (!wen_s) begin
            counter_write_valid <= 1'b0;
            write_state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed testbench for pmu_counter_bank: bus read/write driver tasks,
// an expected-value queue, a single checking task and a final report.
module tb_pmu_counter_bank;

  logic        clk_i;
  logic        rstn_i;
  logic [15:0] events_i;
  logic        counter_read_enable;
  logic [15:0] counter_read_address;
  logic        counter_read_valid;
  logic [63:0] counter_read_data;
  logic        counter_write_enable;
  logic [15:0] counter_write_address;
  logic [63:0] counter_write_data;
  logic        counter_write_valid;
  logic        overflow_irq_o;
  logic [0:0]  read_state;
  logic [0:0]  write_state;

  int vec_count = 0;
  int err_count = 0;
  logic [63:0] exp_q[$];

  pmu_counter_bank dut (
    .clk_i                 (clk_i),
    .rstn_i                (rstn_i),
    .events_i              (events_i),
    .counter_read_enable   (counter_read_enable),
    .counter_read_address  (counter_read_address),
    .counter_read_valid    (counter_read_valid),
    .counter_read_data     (counter_read_data),
    .counter_write_enable  (counter_write_enable),
    .counter_write_address (counter_write_address),
    .counter_write_data    (counter_write_data),
    .counter_write_valid   (counter_write_valid),
    .overflow_irq_o        (overflow_irq_o),
    .read_state            (read_state),
    .write_state           (write_state)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks (called on a negedge, return on a negedge with the FSM idle)
  task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
    int n;
    counter_read_address = a;
    counter_read_enable  = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!counter_read_valid && n < 12);
    check("rd_ack", {63'd0, counter_read_valid}, 64'd1);
    d = counter_read_data;
    counter_read_enable = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (counter_read_valid && n < 12);
    check("rd_release", {63'd0, counter_read_valid}, 64'd0);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    int n;
    counter_write_address = a;
    counter_write_data    = d;
    counter_write_enable  = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!counter_write_valid && n < 12);
    check("wr_ack", {63'd0, counter_write_valid}, 64'd1);
    counter_write_enable = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (counter_write_valid && n < 12);
    check("wr_release", {63'd0, counter_write_valid}, 64'd0);
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [63:0] exp);
    logic [63:0] d;
    exp_q.push_back(exp);
    bus_read(a, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic pulse_events(input logic [15:0] mask, input int cycles);
    events_i = mask;
    repeat (cycles) @(negedge clk_i);
    events_i = '0;
  endtask

  initial begin
    int rises;
    int first;
    int n;
    logic prev;

    rstn_i                = 1'b0;
    events_i              = '0;
    counter_read_enable   = 1'b0;
    counter_read_address  = '0;
    counter_write_enable  = 1'b0;
    counter_write_address = '0;
    counter_write_data    = '0;
    repeat (3) @(negedge clk_i);
    check("rst_rvalid", {63'd0, counter_read_valid}, 64'd0);
    check("rst_rdata", counter_read_data, 64'd0);
    check("rst_wvalid", {63'd0, counter_write_valid}, 64'd0);
    check("rst_irq", {63'd0, overflow_irq_o}, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Read CTRL with explicit handshake latency checks
    counter_read_address = 16'h0000;
    counter_read_enable  = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rd_lat_early", {63'd0, counter_read_valid}, 64'd0);
    @(negedge clk_i);
    check("rd_lat", {63'd0, counter_read_valid}, 64'd1);
    check("rd_ctrl_rst", counter_read_data, 64'd0);
    counter_read_enable = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rd_drop_early", {63'd0, counter_read_valid}, 64'd1);
    @(negedge clk_i);
    check("rd_drop", {63'd0, counter_read_valid}, 64'd0);
    check("rd_drop_data", counter_read_data, 64'd0);
    read_check("rd_ovf_rst", 16'h0008, 64'd0);
    read_check("rd_cnt0_rst", 16'h0010, 64'd0);

    // Counting with EN=1, then frozen with EN=0
    bus_write(16'h0000, 64'd1);
    pulse_events(16'h0008, 5);
    read_check("cnt3_five", 16'h0028, 64'd5);
    bus_write(16'h0000, 64'd0);
    pulse_events(16'h0008, 4);
    read_check("cnt3_frozen", 16'h0028, 64'd5);

    // Wrap and overflow
    bus_write(16'h0000, 64'd1);
    bus_write(16'h0010, 64'hFFFF_FFFF_FFFF_FFFE);
    pulse_events(16'h0001, 3);
    read_check("cnt0_wrap", 16'h0010, 64'd1);
    read_check("ovf_set", 16'h0008, 64'd1);
    check("irq_set", {63'd0, overflow_irq_o}, 64'd1);
    bus_write(16'h0008, 64'd1);
    read_check("ovf_clr", 16'h0008, 64'd0);
    check("irq_clr", {63'd0, overflow_irq_o}, 64'd0);

    // Long-held write with concurrent events: one write at edge 2,
    // then increments at edges 3..19 -> 7 + 17 = 24
    counter_write_address = 16'h0018;
    counter_write_data    = 64'd7;
    counter_write_enable  = 1'b1;
    events_i              = 16'h0002;
    prev  = 1'b0;
    rises = 0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (counter_write_valid && !prev) begin
        rises++;
        if (first == 0) first = c;
      end
      prev = counter_write_valid;
    end
    counter_write_enable = 1'b0;
    events_i             = '0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (counter_write_valid && n < 12);
    check("hold_release", {63'd0, counter_write_valid}, 64'd0);
    check("hold_one_ack", 64'(rises), 64'd1);
    check("hold_ack_lat", 64'(first), 64'd3);
    read_check("hold_cnt1", 16'h0018, 64'd24);

    // CLR while all events active; events stop right after the clear edge
    counter_write_address = 16'h0000;
    counter_write_data    = 64'd2;
    counter_write_enable  = 1'b1;
    events_i              = 16'hFFFF;
    repeat (3) @(negedge clk_i);
    events_i = '0;
    check("clr_ack", {63'd0, counter_write_valid}, 64'd1);
    counter_write_enable = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (counter_write_valid && n < 12);
    check("clr_release", {63'd0, counter_write_valid}, 64'd0);
    read_check("clr_cnt0", 16'h0010, 64'd0);
    read_check("clr_cnt1", 16'h0018, 64'd0);
    read_check("clr_cnt3", 16'h0028, 64'd0);
    read_check("clr_cnt15", 16'h0088, 64'd0);
    read_check("clr_ctrl", 16'h0000, 64'd1);
    pulse_events(16'h0004, 2);
    read_check("after_clr_cnt2", 16'h0020, 64'd2);

    // Asynchronous reset while in read ACK
    counter_read_address = 16'h0020;
    counter_read_enable  = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!counter_read_valid && n < 12);
    check("ack_before_rst", {63'd0, counter_read_valid}, 64'd1);
    check("data_before_rst", counter_read_data, 64'd2);
    #2 rstn_i = 1'b0;
    #1;
    check("async_rvalid", {63'd0, counter_read_valid}, 64'd0);
    check("async_rdata", counter_read_data, 64'd0);
    counter_read_enable = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    read_check("rst_cnt2", 16'h0020, 64'd0);
    read_check("rst_ctrl", 16'h0000, 64'd0);

    // Unmapped accesses
    bus_write(16'h0020, 64'h55);
    bus_write(16'h4000, 64'hDEAD_BEEF);
    read_check("unmapped_rd", 16'h4000, 64'd0);
    read_check("unmapped_cnt2", 16'h0020, 64'h55);
    read_check("unmapped_ctrl", 16'h0000, 64'd0);
    read_check("unmapped_ovf", 16'h0008, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
